// File: rtl/pipe_elastic.sv
// pipe_elastic: elastic register pipeline of DEPTH stages with valid/ready
// handshakes on both ends.
//
// Empty stages absorb items even when the consumer stalls, so bubbles
// collapse. A full pipe still accepts one item per cycle while the consumer
// is taking items.
//
// flush discards every in-flight item and leaves the data registers as they
// are. rst clears both the valid bits and the data registers, and it takes
// priority over flush and over any handshake.
//
// Ports:
//   clk       - sole clock; all state updates on the rising edge
//   rst       - synchronous active-high reset
//   d         - input data (WIDTH bits)
//   in_valid  - d carries a valid item
//   in_ready  - pipeline accepts an item this cycle
//   q         - data of the final stage
//   out_valid - q carries a valid item
//   out_ready - consumer accepts q this cycle
//   flush     - synchronous discard of all in-flight items
//   count     - number of valid stages (0..DEPTH)
module pipe_elastic #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           d,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           q,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH-1:0] rdy;
   logic             accept;

   // ready(i) = !valid(i) || ready(i+1) is unrolled here. A stage is ready when
   // any stage at or below it is empty, or when the consumer is ready. This
   // form avoids a combinational chain that reads its own output.
   always_comb begin
      rdy = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         rdy[i] = out_ready;
         for (int unsigned j = i; j < DEPTH; j++) begin
            if (!vld[j]) rdy[i] = 1'b1;
         end
      end
   end

   assign in_ready  = rdy[0] && !flush && !rst;
   assign accept    = in_valid && in_ready;
   assign q         = data[DEPTH-1];
   assign out_valid = vld[DEPTH-1];

   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         count = count + {{($bits(count)-1){1'b0}}, vld[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) data[i] <= '0;
      end else if (flush) begin
         vld <= '0;
      end else begin
         if (rdy[0]) begin
            vld[0] <= accept;
            if (accept) data[0] <= d;
         end
         // When stage i is ready, stage i-1 is ready as well. An item that
         // moves down is therefore always replaced upstream and is never
         // duplicated.
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
               vld[i] <= vld[i-1];
               if (vld[i-1]) data[i] <= data[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_elastic.sv
// tb_pipe_elastic: directed testbench for pipe_elastic (WIDTH=8, DEPTH=3).
// Inputs change 1 ns after the rising edge. Registered state is checked after
// that edge. in_ready is checked after the inputs for the coming edge have
// settled.
module tb_pipe_elastic;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] q;
   logic       out_valid;
   logic       out_ready;
   logic       flush;
   logic [1:0] count;

   int vectors    = 0;
   int miscompares = 0;

   pipe_elastic #(.WIDTH(8), .DEPTH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .d         (d),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [7:0] eq, input logic ev, input logic [1:0] ec);
      chk({tag, ".q"}, 32'(q), 32'(eq));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
      chk({tag, ".count"}, 32'(count), 32'(ec));
   endtask

   initial begin
      logic [7:0] bp_q [5];
      bp_q[0] = 8'h10; bp_q[1] = 8'h11; bp_q[2] = 8'h12; bp_q[3] = 8'h13; bp_q[4] = 8'h14;

      // ---------------- initial reset ----------------
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = 8'h00;
      settle();
      chk("rst0.in_ready", 32'(in_ready), 32'd0);
      step(); step();
      chk_state("rst0", 8'h00, 1'b0, 2'd0);
      chk("rst0.in_ready_during", 32'(in_ready), 32'd0);
      rst = 1'b0;
      settle();
      chk("rst0.in_ready_after", 32'(in_ready), 32'd1);

      // ---------------- streaming, latency 3 ----------------
      out_ready = 1'b1; in_valid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         d = 8'(k);
         settle();
         chk("stream.in_ready", 32'(in_ready), 32'd1);
         step();
         chk("stream.out_valid", 32'(out_valid), 32'(k >= 3));
         chk("stream.count", 32'(count), 32'(k >= 3 ? 3 : k));
         if (k >= 3) chk("stream.q", 32'(q), 32'(k - 2));
      end
      in_valid = 1'b0;
      step(); chk_state("drain1", 8'h07, 1'b1, 2'd2);
      step(); chk_state("drain2", 8'h08, 1'b1, 2'd1);
      step(); chk_state("drain3", 8'h08, 1'b0, 2'd0);

      // ---------------- reset mid-stream with count=2 ----------------
      out_ready = 1'b0; in_valid = 1'b1;
      d = 8'h33; step();
      d = 8'h34; step();
      chk_state("pre_rst", 8'h08, 1'b0, 2'd2);
      rst = 1'b1;
      settle();
      chk("midrst.in_ready_during", 32'(in_ready), 32'd0);
      step();
      chk_state("midrst1", 8'h00, 1'b0, 2'd0);
      chk("midrst1.in_ready", 32'(in_ready), 32'd0);
      step();
      chk_state("midrst2", 8'h00, 1'b0, 2'd0);
      rst = 1'b0; in_valid = 1'b0;
      settle();
      chk("midrst.in_ready_after", 32'(in_ready), 32'd1);

      // ---------------- backpressure ----------------
      out_ready = 1'b0; in_valid = 1'b1;
      d = 8'h10; settle(); chk("bp.rdy0", 32'(in_ready), 32'd1); step();
      d = 8'h11; settle(); chk("bp.rdy1", 32'(in_ready), 32'd1); step();
      d = 8'h12; settle(); chk("bp.rdy2", 32'(in_ready), 32'd1); step();
      d = 8'h13; settle(); chk("bp.rdy3", 32'(in_ready), 32'd0); step();
      settle(); chk("bp.rdy4", 32'(in_ready), 32'd0); step();
      chk_state("bp.full", 8'h10, 1'b1, 2'd3);
      // Full pipe with consumer ready: deliver and accept on the same edge.
      out_ready = 1'b1;
      settle();
      chk("bp.rdy_full_drain", 32'(in_ready), 32'd1);
      chk("bp.q0", 32'(q), 32'(bp_q[0]));
      step();
      chk("bp.count_a", 32'(count), 32'd3);
      d = 8'h14;
      settle();
      chk("bp.q1", 32'(q), 32'(bp_q[1]));
      step();
      chk("bp.count_b", 32'(count), 32'd3);
      in_valid = 1'b0;
      settle(); chk_state("bp.o2", bp_q[2], 1'b1, 2'd3); step();
      chk_state("bp.o3", bp_q[3], 1'b1, 2'd2); step();
      chk_state("bp.o4", bp_q[4], 1'b1, 2'd1); step();
      chk_state("bp.empty", bp_q[4], 1'b0, 2'd0);

      // ---------------- bubble collapse ----------------
      out_ready = 1'b0;
      in_valid = 1'b1; d = 8'hA0; step();
      in_valid = 1'b0; step();
      in_valid = 1'b1; d = 8'hA1; step();
      in_valid = 1'b0; step(); step();
      chk_state("bubble", 8'hA0, 1'b1, 2'd2);
      chk("bubble.in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      step(); chk_state("bubble.o1", 8'hA1, 1'b1, 2'd1);
      step(); chk_state("bubble.o2", 8'hA1, 1'b0, 2'd0);

      // ---------------- flush ----------------
      out_ready = 1'b0; in_valid = 1'b1;
      d = 8'h20; step();
      d = 8'h21; step();
      d = 8'h22; step();
      chk_state("fl.full", 8'h20, 1'b1, 2'd3);
      flush = 1'b1; d = 8'h55; out_ready = 1'b1;
      settle();
      chk("fl.in_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk_state("fl.after", 8'h20, 1'b0, 2'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("fl.no_55", 32'(out_valid), 32'd0);
      end

      // ---------------- rst and flush together ----------------
      out_ready = 1'b0; in_valid = 1'b1;
      d = 8'h40; step();
      d = 8'h41; step();
      chk_state("rf.pre", 8'h20, 1'b0, 2'd2);
      rst = 1'b1; flush = 1'b1; d = 8'h66; out_ready = 1'b1;
      settle();
      chk("rf.in_ready_during", 32'(in_ready), 32'd0);
      step();
      chk_state("rf.1", 8'h00, 1'b0, 2'd0);
      step();
      chk_state("rf.2", 8'h00, 1'b0, 2'd0);
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      settle();
      chk("rf.in_ready_after", 32'(in_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rf.no_item", 32'(out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
